// File: rtl/encryption_arbiter.sv
// Round-robin arbiter sharing one AES-128 encryption core between two
// requesters; sequences the core clear/load/done handshake per job.
// Ports: clock, resetModule (async active-low); req0/req1, inputData0/1,
//   key0/key1 from requesters; outputData, done0/done1, busy, timeoutFlag
//   back to them; coreInputData, coreKey, coreInputsLoadedFlag,
//   coreResetModule to the core; coreOutputData, coreDataEncryptedFlag
//   from the core.
// Optional: define ENC_ARB_TIMEOUT_EN to abort jobs stuck in BUSY for
//   TIMEOUT_CYCLES cycles.
module encryption_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clock,
  input  logic         resetModule,
  input  logic         req0,
  input  logic         req1,
  input  logic [127:0] inputData0,
  input  logic [127:0] inputData1,
  input  logic [127:0] key0,
  input  logic [127:0] key1,
  output logic [127:0] outputData,
  output logic         done0,
  output logic         done1,
  output logic         busy,
  output logic         timeoutFlag,
  output logic [127:0] coreInputData,
  output logic [127:0] coreKey,
  output logic         coreInputsLoadedFlag,
  output logic         coreResetModule,
  input  logic [127:0] coreOutputData,
  input  logic         coreDataEncryptedFlag
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_LOAD,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic grant_id;
  logic last_grant;
  logic win;
  logic grab;
  logic finish;
  logic timeout_hit;

  // The busy counter is 16 bits wide.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65536) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be in 1..65536");
  end

  // Sole requester wins; on contention the one not served last wins.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = ~last_grant;
    end else begin
      win = req1;
    end
  end

  assign grab   = (state == S_IDLE) && (req0 || req1);
  assign finish = (state == S_BUSY) &&
                  (coreDataEncryptedFlag || timeout_hit);

  // Core is held in clear for the whole CLEAR state, which is also
  // the reset state.
  assign coreResetModule = (state == S_CLEAR);

`ifdef ENC_ARB_TIMEOUT_EN
  logic [15:0] busy_cnt;
  logic        tmo_q;

  always_ff @(posedge clock or negedge resetModule) begin
    if (!resetModule) begin
      busy_cnt <= '0;
    end else if (state != S_BUSY) begin
      busy_cnt <= '0;
    end else begin
      busy_cnt <= busy_cnt + 16'd1;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th BUSY cycle.
  assign timeout_hit = (state == S_BUSY) &&
                       (busy_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge resetModule) begin
    if (!resetModule) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= finish && !coreDataEncryptedFlag;
    end
  end

  assign timeoutFlag = tmo_q;
`else
  assign timeout_hit = 1'b0;
  assign timeoutFlag = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetModule) begin
    if (!resetModule) begin
      state <= S_CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_CLEAR: state_nx = S_IDLE;
      S_IDLE: begin
        if (req0 || req1) begin
          state_nx = S_LOAD;
        end
      end
      S_LOAD: state_nx = S_BUSY;
      S_BUSY: begin
        if (coreDataEncryptedFlag || timeout_hit) begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_CLEAR;
      default: state_nx = S_CLEAR;
    endcase
  end

  // busy is registered from the next state so that it reads 0 in the
  // reset CLEAR state yet is high in the CLEAR that follows a job.
  always_ff @(posedge clock or negedge resetModule) begin
    if (!resetModule) begin
      grant_id             <= 1'b0;
      last_grant           <= 1'b1;
      coreInputData        <= '0;
      coreKey              <= '0;
      outputData           <= '0;
      coreInputsLoadedFlag <= 1'b0;
      done0                <= 1'b0;
      done1                <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      busy                 <= (state_nx != S_IDLE);
      coreInputsLoadedFlag <= (state_nx == S_LOAD) ||
                              (state_nx == S_BUSY);
      done0                <= finish && !grant_id;
      done1                <= finish && grant_id;
      if (grab) begin
        grant_id      <= win;
        last_grant    <= win;
        coreInputData <= win ? inputData1 : inputData0;
        coreKey       <= win ? key1 : key0;
      end
      if (finish) begin
        outputData <= coreDataEncryptedFlag ?
                      coreOutputData : '0;
      end
    end
  end

endmodule

// File: tb/tb_encryption_arbiter.sv
// Directed self-checking bench for encryption_arbiter with a
// fixed-latency behavioural core holding known AES-128 vectors.
`timescale 1ns/1ps
module tb_encryption_arbiter;

  localparam int LAT = 3;
  localparam int TMO = 8;
  localparam logic [127:0] PT =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT0 =
    128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clock;
  logic         resetModule;
  logic         req0, req1;
  logic [127:0] inputData0, inputData1;
  logic [127:0] key0, key1;
  logic [127:0] outputData;
  logic         done0, done1, busy, timeoutFlag;
  logic [127:0] coreInputData, coreKey;
  logic         coreInputsLoadedFlag, coreResetModule;
  logic [127:0] coreOutputData;
  logic         coreDataEncryptedFlag;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done0 = 0;
  int n_done1 = 0;
  int core_cnt;
  bit stall = 0;

  encryption_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock                (clock),
    .resetModule          (resetModule),
    .req0                 (req0),
    .req1                 (req1),
    .inputData0           (inputData0),
    .inputData1           (inputData1),
    .key0                 (key0),
    .key1                 (key1),
    .outputData           (outputData),
    .done0                (done0),
    .done1                (done1),
    .busy                 (busy),
    .timeoutFlag          (timeoutFlag),
    .coreInputData        (coreInputData),
    .coreKey              (coreKey),
    .coreInputsLoadedFlag (coreInputsLoadedFlag),
    .coreResetModule      (coreResetModule),
    .coreOutputData       (coreOutputData),
    .coreDataEncryptedFlag(coreDataEncryptedFlag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [127:0] aes_ref(
    input logic [127:0] d, input logic [127:0] k);
    if (d == PT && k == KEY) return CT1;
    if (d == '0 && k == '0) return CT0;
    return d ^ k ^ 128'hdeadbeef;
  endfunction

  // Core: flag rises in the LAT-th cycle after the load cycle.
  always @(posedge clock or negedge resetModule) begin
    if (!resetModule) core_cnt <= 0;
    else if (!coreInputsLoadedFlag || coreResetModule) core_cnt <= 0;
    else core_cnt <= core_cnt + 1;
  end
  assign coreDataEncryptedFlag =
    coreInputsLoadedFlag && !stall && (core_cnt >= LAT);
  assign coreOutputData = aes_ref(coreInputData, coreKey);

  always @(negedge clock) begin
    if (done0) n_done0 <= n_done0 + 1;
    if (done1) n_done1 <= n_done1 + 1;
  end

  task automatic wait_done(input int lim, output bit ok, output int n);
    ok = 0;
    n = 0;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clock);
      if (done0 || done1) begin
        ok = 1;
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    resetModule = 1'b0;
    repeat (2) @(negedge clock);
    resetModule = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    resetModule = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (outputData !== '0) begin
      n_bad++;
      $display("FAIL rst_out: got %h want 0", outputData);
    end
    n_cmp++;
    if ({done0, done1, busy, timeoutFlag, coreInputsLoadedFlag}
        !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_flags: got %b want 00000",
        {done0, done1, busy, timeoutFlag, coreInputsLoadedFlag});
    end
    n_cmp++;
    if ({coreInputData, coreKey} !== 256'b0) begin
      n_bad++;
      $display("FAIL rst_core_ops: got %h %h want 0",
        coreInputData, coreKey);
    end
    n_cmp++;
    if (coreResetModule !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_core_clr: got %b want 1", coreResetModule);
    end
    resetModule = 1'b1;
    #1;
    n_cmp++;
    if (coreResetModule !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_after_rel: got %b want 1", coreResetModule);
    end
    @(negedge clock);
    n_cmp++;
    if ({coreResetModule, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_after_rel: got %b want 00",
        {coreResetModule, busy});
    end
  endtask

  task automatic test_single_job();
    bit ok;
    int w;
    int d0, d1;
    d0 = n_done0;
    d1 = n_done1;
    inputData0 = PT;
    key0 = KEY;
    req0 = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({coreInputsLoadedFlag, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL load_latency: got %b want 11",
        {coreInputsLoadedFlag, busy});
    end
    n_cmp++;
    if ({coreInputData, coreKey} !== {PT, KEY}) begin
      n_bad++;
      $display("FAIL load_ops: got %h %h want %h %h",
        coreInputData, coreKey, PT, KEY);
    end
    wait_done(20, ok, w);
    w = w + 1;
    n_cmp++;
    if (!ok || w != LAT + 2) begin
      n_bad++;
      $display("FAIL single_latency: got ok=%0d n=%0d want n=%0d",
        ok, w, LAT + 2);
    end
    n_cmp++;
    if ({done0, done1} !== 2'b10) begin
      n_bad++;
      $display("FAIL single_done: got %b want 10", {done0, done1});
    end
    n_cmp++;
    if (outputData !== CT1) begin
      n_bad++;
      $display("FAIL single_ct: got %h want %h", outputData, CT1);
    end
    req0 = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (done0 !== 1'b0) begin
      n_bad++;
      $display("FAIL done_width: got %b want 0", done0);
    end
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || outputData !== CT1) begin
      n_bad++;
      $display("FAIL single_idle: got busy=%b out=%h want 0 %h",
        busy, outputData, CT1);
    end
    n_cmp++;
    if (n_done0 - d0 != 1 || n_done1 != d1) begin
      n_bad++;
      $display("FAIL single_counts: got %0d %0d want 1 0",
        n_done0 - d0, n_done1 - d1);
    end
  endtask

  task automatic test_contention();
    bit ok;
    int w;
    do_reset();
    inputData0 = PT;
    key0 = KEY;
    inputData1 = '0;
    key1 = '0;
    req0 = 1'b1;
    req1 = 1'b1;
    wait_done(20, ok, w);
    n_cmp++;
    if (!ok || {done0, done1} !== 2'b10 || outputData !== CT1) begin
      n_bad++;
      $display("FAIL cont_first: got ok=%0d d=%b out=%h want 10 %h",
        ok, {done0, done1}, outputData, CT1);
    end
    req0 = 1'b0;
    wait_done(20, ok, w);
    n_cmp++;
    if (!ok || {done0, done1} !== 2'b01 || outputData !== CT0) begin
      n_bad++;
      $display("FAIL cont_second: got ok=%0d d=%b out=%h want 01 %h",
        ok, {done0, done1}, outputData, CT0);
    end
    n_cmp++;
    if (w != LAT + 4) begin
      n_bad++;
      $display("FAIL cont_period: got %0d want %0d", w, LAT + 4);
    end
    req1 = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_round_robin();
    bit ok;
    int w;
    int id;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      id = k % 2;
      wait_done(30, ok, w);
      n_cmp++;
      if (!ok || {done0, done1} !== (id == 1 ? 2'b01 : 2'b10)) begin
        n_bad++;
        $display("FAIL rr_grant%0d: got ok=%0d d=%b want id %0d",
          k, ok, {done0, done1}, id);
      end
      n_cmp++;
      if (outputData !== (id == 1 ? CT0 : CT1)) begin
        n_bad++;
        $display("FAIL rr_ct%0d: got %h", k, outputData);
      end
      n_cmp++;
      if (w != (k == 0 ? LAT + 2 : LAT + 4)) begin
        n_bad++;
        $display("FAIL rr_period%0d: got %0d want %0d", k, w,
          k == 0 ? LAT + 2 : LAT + 4);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_stability();
    bit ok;
    int w;
    inputData0 = PT;
    key0 = KEY;
    req0 = 1'b1;
    repeat (2) @(negedge clock);
    inputData0 = ~PT;
    @(negedge clock);
    n_cmp++;
    if (coreInputData !== PT) begin
      n_bad++;
      $display("FAIL stable_op: got %h want %h", coreInputData, PT);
    end
    wait_done(20, ok, w);
    n_cmp++;
    if (!ok || outputData !== CT1) begin
      n_bad++;
      $display("FAIL stable_ct: got ok=%0d out=%h want %h",
        ok, outputData, CT1);
    end
    req0 = 1'b0;
    inputData0 = PT;
    repeat (2) @(negedge clock);
  endtask

`ifdef ENC_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int w;
    stall = 1;
    req0 = 1'b1;
    wait_done(40, ok, w);
    n_cmp++;
    if (!ok || w != TMO + 2) begin
      n_bad++;
      $display("FAIL tmo_latency: got ok=%0d n=%0d want %0d",
        ok, w, TMO + 2);
    end
    n_cmp++;
    if ({done0, done1, timeoutFlag} !== 3'b101) begin
      n_bad++;
      $display("FAIL tmo_flags: got %b want 101",
        {done0, done1, timeoutFlag});
    end
    n_cmp++;
    if (outputData !== '0) begin
      n_bad++;
      $display("FAIL tmo_out: got %h want 0", outputData);
    end
    req0 = 1'b0;
    stall = 0;
    @(negedge clock);
    n_cmp++;
    if ({timeoutFlag, coreResetModule} !== 2'b01) begin
      n_bad++;
      $display("FAIL tmo_clear: got %b want 01",
        {timeoutFlag, coreResetModule});
    end
    @(negedge clock);
  endtask
`else
  task automatic test_timeout();
    bit ok;
    int w;
    stall = 1;
    req0 = 1'b1;
    wait_done(50, ok, w);
    n_cmp++;
    if (ok !== 1'b0) begin
      n_bad++;
      $display("FAIL no_tmo_wait: got done after %0d want none", w);
    end
    n_cmp++;
    if ({busy, coreInputsLoadedFlag, timeoutFlag} !== 3'b110) begin
      n_bad++;
      $display("FAIL no_tmo_state: got %b want 110",
        {busy, coreInputsLoadedFlag, timeoutFlag});
    end
    stall = 0;
    wait_done(10, ok, w);
    n_cmp++;
    if (!ok || outputData !== CT1 || timeoutFlag !== 1'b0) begin
      n_bad++;
      $display("FAIL no_tmo_finish: got ok=%0d out=%h tf=%b",
        ok, outputData, timeoutFlag);
    end
    req0 = 1'b0;
    repeat (2) @(negedge clock);
  endtask
`endif

  task automatic test_reset_midjob();
    bit ok;
    int w;
    int d0;
    d0 = n_done0;
    stall = 1;
    inputData0 = PT;
    key0 = KEY;
    req0 = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (coreInputsLoadedFlag !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pre: got %b want 1", coreInputsLoadedFlag);
    end
    resetModule = 1'b0;
    #1;
    n_cmp++;
    if ({coreInputsLoadedFlag, coreResetModule} !== 2'b01) begin
      n_bad++;
      $display("FAIL mid_async: got %b want 01",
        {coreInputsLoadedFlag, coreResetModule});
    end
    n_cmp++;
    if ({busy, done0, done1} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_outs: got %b want 000", {busy, done0, done1});
    end
    repeat (2) @(negedge clock);
    stall = 0;
    resetModule = 1'b1;
    @(negedge clock);
    wait_done(20, ok, w);
    n_cmp++;
    if (!ok || {done0, done1} !== 2'b10 || outputData !== CT1) begin
      n_bad++;
      $display("FAIL mid_rerun: got ok=%0d d=%b out=%h want 10 %h",
        ok, {done0, done1}, outputData, CT1);
    end
    req0 = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (n_done0 - d0 != 1) begin
      n_bad++;
      $display("FAIL mid_count: got %0d done0 pulses want 1",
        n_done0 - d0);
    end
  endtask

  initial begin
    resetModule = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    inputData0 = '0;
    inputData1 = '0;
    key0 = '0;
    key1 = '0;
    #2;
    test_reset();
    test_single_job();
    test_contention();
    test_round_robin();
    test_stability();
    test_timeout();
    test_reset_midjob();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/encryption_arbiter.md
# encryption_arbiter

Shares one `encryption` core between two requesters. It uses round-robin arbitration and sequences the core's load, done and clear handshake for each job. Each winning requester's plaintext and key are captured, presented to the core, and the ciphertext is returned with a one-cycle done pulse. The block sits between the two requester front-ends and the single AES-128 `encryption` instance.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: BUSY-state cycle limit before the job is aborted. Used only with `ENC_ARB_TIMEOUT_EN`.

Ports:
- `clock`  in  1  single system clock; all logic on rising edge.
- `resetModule`  in  1  reset, asynchronous, active-low.
- `req0`, `req1`  in  1  job request. Held high with data stable until the matching done pulse.
- `inputData0`, `inputData1`  in  128  plaintext per requester.
- `key0`, `key1`  in  128  key per requester.
- `outputData`  out  128  ciphertext of the last completed job. Registered.
- `done0`, `done1`  out  1  one-cycle completion pulse for requester 0 / 1.
- `busy`  out  1  high in any state other than IDLE.
- `timeoutFlag`  out  1  high with the done pulse of an aborted job.
- `coreInputData`, `coreKey`  out  128  registered operands to the core.
- `coreInputsLoadedFlag`  out  1  core start level.
- `coreResetModule`  out  1  core clear, active-high.
- `coreOutputData`  in  128  core ciphertext.
- `coreDataEncryptedFlag`  in  1  core completion level.

## Operation
- FSM states: CLEAR, IDLE, LOAD, BUSY, DONE. The reset state is CLEAR.
- **CLEAR**
  - `coreResetModule`=1 and `coreInputsLoadedFlag`=0.
  - Next state is IDLE unconditionally.
- **IDLE**
  - If any req is high, arbitrate and go to LOAD. Otherwise stay.
  - Arbitration: a sole requester wins. If both are high, the requester other than `lastGrant` wins.
  - On leaving IDLE, register `grantId`, latch the winner's data/key into `coreInputData`/`coreKey`, and set `lastGrant`=`grantId`.
- **LOAD**
  - `coreInputsLoadedFlag` is set to 1 and held through BUSY.
  - Next state is BUSY.
- **BUSY**
  - Wait for `coreDataEncryptedFlag`=1.
  - When it is seen, register `coreOutputData` into `outputData`, clear `coreInputsLoadedFlag`, and go to DONE.
- **DONE**
  - `done<grantId>`=1 for exactly this cycle.
  - Next state is CLEAR.
- A requester's req is ignored during DONE and during the following CLEAR cycle. This lets the requester drop req without triggering a spurious re-grant.
- `lastGrant` resets to 1, so requester 0 wins the first contention.
- Operand registers change only on the IDLE→LOAD transition.
- Requester input changes at any other time have no effect.

## Timing
- Reset values:
  - All outputs are 0, except `coreResetModule`=1.
  - Asserting `resetModule` mid-job aborts the job with no done pulse. State goes to CLEAR.
  - `coreResetModule` stays 1 during reset and for the first clock after release.
- Latency:
  - Req sampled high in IDLE at edge N: LOAD at N+1, and `coreInputsLoadedFlag` is high from N+1.
  - `coreDataEncryptedFlag` first sampled high at edge M: `outputData` and `done` are valid from M+1 for one cycle. CLEAR is at M+2 and IDLE at M+3.
  - Minimum job-to-job period = core latency + 4 cycles.
- Simultaneous events:
  - Both reqs rising in the same cycle: resolved by `lastGrant`.
  - A req arriving while busy waits with no loss.
  - A starved requester is served next, guaranteed.
- `outputData` holds its value until the next completed job.

## Configuration
- `ENC_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entering BUSY and increments each BUSY cycle.
  - When the counter reaches `TIMEOUT_CYCLES`, the FSM goes to DONE. `outputData` is set to 0 and `timeoutFlag`=1 with the done pulse.
  - The following CLEAR resets the core.
- `ENC_ARB_TIMEOUT_EN` undefined:
  - There is no counter; BUSY waits indefinitely.
  - `timeoutFlag` is tied to 0.

## Test plan
- **Single job**
  - Stimulus: req0 only, data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f.
  - Required: a single done0 pulse, `outputData`=69c4e0d86a7b0430d8cdb78070b4c55a, done1 never high.
- **Contention after reset**
  - Stimulus: req0 and req1 rise together. req1 carries all-zero data and key.
  - Required: requester 0 is served first. Then done1 pulses with `outputData`=66e94bd4ef8a2c3b884cfa59ca342b2e.
- **Round-robin fairness**
  - Stimulus: both reqs held for 4 jobs.
  - Required: grant order 0,1,0,1. Back-to-back start interval is exactly core latency + 4 cycles.
- **Reset mid-job**
  - Stimulus: `resetModule` low during BUSY.
  - Required: `coreInputsLoadedFlag` drops asynchronously, no done pulse, `coreResetModule`=1. A new req0 after release completes correctly.
- **Timeout** (`ENC_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8)
  - Stimulus: core model never asserts `coreDataEncryptedFlag`.
  - Required: done0 and `timeoutFlag` pulse after 8 BUSY cycles, with `outputData`=0.
- **Stimulus stability**
  - Stimulus: change `inputData0` while BUSY.
  - Required: `coreInputData` unchanged and the result matches the original plaintext.
